// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_pkg
//  Description : Shared FP definitions: operand class encodings, default
//                IEEE-754 single-precision field widths, exponent bias helper
//                and the state type of the unpack stream buffer.
//  Revision    : 1.0  initial release
// ============================================================================
package fp_pkg;

    localparam int FP_E_WIDTH = 8;
    localparam int FP_M_WIDTH = 23;

    typedef enum logic [2:0] {
        FP_ZERO = 3'd0,
        FP_SUB  = 3'd1,
        FP_NORM = 3'd2,
        FP_INF  = 3'd3,
        FP_QNAN = 3'd4,
        FP_SNAN = 3'd5
    } fp_class_t;

    // Output register / skid occupancy of fp_unpack
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } fp_unpack_state_t;

    function automatic int bias(input int e_width);
        return (2 ** (e_width - 1)) - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_lzc.sv
`default_nettype none
// ============================================================================
//  Module      : fp_lzc
//  Description : Combinational leading-zero counter. o_count is the number of
//                zero bits above the most significant set bit of i_data
//                (W when i_data is all zeros).
//  Ports       : i_data  [W-1:0]   value to scan
//                o_count [CW-1:0]  leading-zero count
//  Revision    : 1.0  initial release
// ============================================================================
module fp_lzc #(
    parameter int W  = 23,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  i_data,
    output logic [CW-1:0] o_count
);

    // Scan upward so the highest set bit is the last one to assign.
    always_comb begin
        o_count = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (i_data[i]) begin
                o_count = CW'(W - 1 - i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_unpack.sv
`default_nettype none
// ============================================================================
//  Module      : fp_unpack
//  Description : FP operand front end. Splits packed IEEE-754 words into
//                sign, extended biased exponent and mantissa with explicit
//                hidden bit, and classifies them. Registered valid/ready
//                stream with a one-entry skid buffer (full throughput).
//  Build macro : FP_UNPACK_SUBNORM_NORM_EN - when defined, subnormals are
//                normalised (negative out_e); otherwise they flush to zero.
//  Ports       : clk, reset (sync, active-low)
//                in_valid/in_ready/in_word    packed {sign, exp, frac} input
//                out_valid/out_ready          output handshake
//                out_sign, out_e, out_m       unpacked fields
//                out_class                    fp_class_t encoding
//  Revision    : 1.0  initial release
// ============================================================================
module fp_unpack
    import fp_pkg::*;
#(
    parameter int E_WIDTH = FP_E_WIDTH,
    parameter int M_WIDTH = FP_M_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [E_WIDTH+M_WIDTH:0]   in_word,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_sign,
    output logic [E_WIDTH+1:0]         out_e,
    output logic [M_WIDTH:0]           out_m,
    output logic [2:0]                 out_class
);

    // ------------------------------------------------------------------
    // Field split and decode
    // ------------------------------------------------------------------
    logic               w_sign;
    logic [E_WIDTH-1:0] w_exp;
    logic [M_WIDTH-1:0] w_frac;
    logic [E_WIDTH+1:0] w_dec_e;
    logic [M_WIDTH:0]   w_dec_m;
    fp_class_t          w_dec_class;

    assign w_sign = in_word[E_WIDTH+M_WIDTH];
    assign w_exp  = in_word[E_WIDTH+M_WIDTH-1:M_WIDTH];
    assign w_frac = in_word[M_WIDTH-1:0];

`ifdef FP_UNPACK_SUBNORM_NORM_EN
    localparam int c_lz_w = $clog2(M_WIDTH + 1);

    logic [c_lz_w-1:0]  w_lz;
    logic [M_WIDTH-1:0] w_frac_norm;

    fp_lzc #(
        .W  (M_WIDTH),
        .CW (c_lz_w)
    ) u_lzc (
        .i_data  (w_frac),
        .o_count (w_lz)
    );

    // Leading one lands in the top fraction bit and becomes the hidden bit.
    assign w_frac_norm = w_frac << w_lz;
`endif

    always_comb begin
        w_dec_e     = '0;
        w_dec_m     = '0;
        w_dec_class = FP_ZERO;
        if (w_exp == {E_WIDTH{1'b1}}) begin
            w_dec_e = {2'b00, w_exp};
            w_dec_m = {1'b0, w_frac};
            if (w_frac == '0) begin
                w_dec_class = FP_INF;
            end else if (w_frac[M_WIDTH-1]) begin
                w_dec_class = FP_QNAN;
            end else begin
                w_dec_class = FP_SNAN;
            end
        end else if (w_exp != '0) begin
            w_dec_e     = {2'b00, w_exp};
            w_dec_m     = {1'b1, w_frac};
            w_dec_class = FP_NORM;
        end else if (w_frac != '0) begin
`ifdef FP_UNPACK_SUBNORM_NORM_EN
            // A subnormal's effective exponent is 1; shifting by lz+1 to
            // expose the hidden bit gives 1-(lz+1) = -lz.
            w_dec_e     = (E_WIDTH+2)'(0) - (E_WIDTH+2)'(w_lz);
            w_dec_m     = {w_frac_norm, 1'b0};
            w_dec_class = FP_SUB;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Stream control
    // ------------------------------------------------------------------
    fp_unpack_state_t r_state;
    fp_unpack_state_t w_state_nxt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             w_accept;
    logic             w_drain;
    logic             w_load_out;
    logic             w_load_skid;
    logic             w_skid_to_out;

    assign w_accept = in_valid && r_in_ready;
    assign w_drain  = r_out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt != ST_TWO);
            r_out_valid <= (w_state_nxt != ST_EMPTY);
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_load_out    = 1'b0;
        w_load_skid   = 1'b0;
        w_skid_to_out = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_load_out  = 1'b1;
                    w_state_nxt = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_accept && !w_drain) begin
                    w_load_skid = 1'b1;
                    w_state_nxt = ST_TWO;
                end else if (w_drain && !w_accept) begin
                    w_state_nxt = ST_EMPTY;
                end else if (w_accept && w_drain) begin
                    w_load_out  = 1'b1;
                end
            end
            ST_TWO: begin
                if (w_drain) begin
                    w_skid_to_out = 1'b1;
                    w_state_nxt   = ST_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output register and skid buffer
    // ------------------------------------------------------------------
    logic               r_out_sign;
    logic [E_WIDTH+1:0] r_out_e;
    logic [M_WIDTH:0]   r_out_m;
    logic [2:0]         r_out_class;
    logic               r_skid_sign;
    logic [E_WIDTH+1:0] r_skid_e;
    logic [M_WIDTH:0]   r_skid_m;
    logic [2:0]         r_skid_class;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_out_sign   <= 1'b0;
            r_out_e      <= '0;
            r_out_m      <= '0;
            r_out_class  <= '0;
            r_skid_sign  <= 1'b0;
            r_skid_e     <= '0;
            r_skid_m     <= '0;
            r_skid_class <= '0;
        end else begin
            if (w_load_out) begin
                r_out_sign  <= w_sign;
                r_out_e     <= w_dec_e;
                r_out_m     <= w_dec_m;
                r_out_class <= w_dec_class;
            end else if (w_skid_to_out) begin
                r_out_sign  <= r_skid_sign;
                r_out_e     <= r_skid_e;
                r_out_m     <= r_skid_m;
                r_out_class <= r_skid_class;
            end
            if (w_load_skid) begin
                r_skid_sign  <= w_sign;
                r_skid_e     <= w_dec_e;
                r_skid_m     <= w_dec_m;
                r_skid_class <= w_dec_class;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_sign  = r_out_sign;
    assign out_e     = r_out_e;
    assign out_m     = r_out_m;
    assign out_class = r_out_class;

endmodule
`default_nettype wire

// File: tb/tb_fp_unpack.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_unpack
//  Description : Self-checking bench for fp_unpack (single precision).
//                Honours FP_UNPACK_SUBNORM_NORM_EN for subnormal expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fp_unpack;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_word;
    logic        out_valid;
    logic        out_ready;
    logic        out_sign;
    logic [9:0]  out_e;
    logic [23:0] out_m;
    logic [2:0]  out_class;

    fp_unpack #(.E_WIDTH(8), .M_WIDTH(23)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sign  (out_sign),
        .out_e     (out_e),
        .out_m     (out_m),
        .out_class (out_class)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int n_drain = 0;
    int cyc     = 0;
    bit lat_mode = 1'b0;

    typedef struct {
        logic [37:0] v;
        int          cyc;
        bit          lat;
    } sb_t;
    sb_t sb_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: {sign, e[9:0], m[23:0], class[2:0]} from IEEE-754 rules
    function automatic logic [37:0] model(input logic [31:0] w);
        int          ef;
        int          f;
        int          e;
        int          m;
        int          cls;
        int          n;
        logic [9:0]  e10;
        ef  = int'(w[30:23]);
        f   = int'(w[22:0]);
        e   = 0;
        m   = 0;
        cls = 0;
        if (ef == 255) begin
            e   = 255;
            m   = f;
            cls = (f == 0) ? 3 : ((f >= (1 << 22)) ? 4 : 5);
        end else if (ef > 0) begin
            e   = ef;
            m   = f + (1 << 23);
            cls = 2;
        end else if (f != 0) begin
`ifdef FP_UNPACK_SUBNORM_NORM_EN
            n = 0;
            m = f;
            while (m < (1 << 22)) begin
                m = m * 2;
                n++;
            end
            m   = m * 2;
            e   = (1024 - n) % 1024;
            cls = 1;
`else
            n = 0;
`endif
        end
        e10 = e[9:0];
        return {w[31], e10, m[23:0], cls[2:0]};
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        int          r;
        logic [7:0]  e;
        logic [22:0] f;
        r = int'($urandom % 8);
        e = 8'($urandom);
        f = 23'($urandom);
        case (r)
            0: begin e = 8'd0; f = 23'd0; end
            1: begin e = 8'd0; f = f >> ($urandom % 23); if (f == 0) f = 23'd1; end
            2: begin e = 8'hFF; f = 23'd0; end
            3: e = 8'hFF;
            default: if (e == 8'hFF || e == 8'h00) e = 8'd100;
        endcase
        w = {1'($urandom), e, f};
        return w;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: handshakes are decided at the coming posedge; inputs and
    // outputs are stable at the negedge before it.
    always @(negedge clk) begin
        sb_t ent;
        if (!reset) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_drain++;
                if (sb_q.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    ent = sb_q.pop_front();
                    chk("out_fields", {out_sign, out_e, out_m, out_class}, ent.v);
                    if (ent.lat) chk("latency", cyc - ent.cyc, 1);
                end
            end
            if (in_valid && in_ready) begin
                ent.v   = model(in_word);
                ent.cyc = cyc;
                ent.lat = lat_mode;
                sb_q.push_back(ent);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w);
        int k;
        in_valid = 1'b1;
        in_word  = w;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) begin
                step();
                break;
            end
            step();
        end
        if (k == 50) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    initial begin
        int d0;
        int k;
        bit acc;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_word   = '0;
        out_ready = 1'b0;
        repeat (3) step();
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_fields", {out_sign, out_e, out_m, out_class}, 0);
        step();
        reset = 1'b1;

        // Directed decode cases
        out_ready = 1'b1;
        send(32'h3F80_0000);
        @(negedge clk);
        chk("one_valid", out_valid, 1);
        chk("one_fields", {out_sign, out_e, out_m, out_class},
            {1'b0, 10'd127, 24'h80_0000, 3'd2});
        send(32'hFF80_0000);
        @(negedge clk);
        chk("inf_fields", {out_sign, out_e, out_m, out_class},
            {1'b1, 10'd255, 24'h0, 3'd3});
        send(32'h7FC0_0000);
        @(negedge clk);
        chk("qnan_class", out_class, 3'd4);
        send(32'h7F80_0001);
        @(negedge clk);
        chk("snan_class", out_class, 3'd5);
        send(32'h0000_0001);
        @(negedge clk);
`ifdef FP_UNPACK_SUBNORM_NORM_EN
        chk("sub_fields", {out_sign, out_e, out_m, out_class},
            {1'b0, 10'h3EA, 24'h80_0000, 3'd1});
`else
        chk("ftz_fields", {out_sign, out_e, out_m, out_class},
            {1'b0, 10'h0, 24'h0, 3'd0});
`endif
        send(32'h8000_0000);
        @(negedge clk);
        chk("negzero_fields", {out_sign, out_e, out_m, out_class}, {1'b1, 37'h0});
        step();

        // Backpressure: three words, consumer stalled
        d0        = n_drain;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_word   = rand_word();
        @(negedge clk);
        chk("bp_rdy_first", in_ready, 1);
        step();
        in_word = rand_word();
        step();
        in_word = rand_word();
        @(negedge clk);
        chk("bp_rdy_low", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        step();
        out_ready = 1'b1;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            acc = in_ready;
            step();
            if (acc) break;
        end
        if (k == 20) chk("bp_timeout", 0, 1);
        in_valid = 1'b0;
        repeat (4) step();
        chk("bp_drains", n_drain - d0, 3);
        chk("bp_queue_empty", sb_q.size(), 0);

        // Full-rate streaming
        d0       = n_drain;
        lat_mode = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1;
            in_word  = rand_word();
            @(negedge clk);
            if (!in_ready) chk("stream_in_ready", in_ready, 1);
            step();
        end
        in_valid = 1'b0;
        step();
        lat_mode = 1'b0;
        step();
        chk("stream_drains", n_drain - d0, 100);

        // Random valid/ready traffic
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            step();
            if (acc || !in_valid) begin
                in_valid = ($urandom % 4) != 0;
                in_word  = rand_word();
            end
            out_ready = ($urandom % 3) != 0;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (5) step();
        chk("rand_queue_empty", sb_q.size(), 0);

        // Reset while full: held words must vanish
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_word   = 32'h4000_0000;
        step();
        in_word   = 32'h4040_0000;
        step();
        in_valid  = 1'b0;
        @(negedge clk);
        chk("two_in_ready", in_ready, 0);
        reset = 1'b0;
        step();
        @(negedge clk);
        chk("rst2_out_valid", out_valid, 0);
        chk("rst2_in_ready", in_ready, 1);
        chk("rst2_fields", {out_sign, out_e, out_m, out_class}, 0);
        reset     = 1'b1;
        out_ready = 1'b1;
        d0        = n_drain;
        repeat (5) step();
        chk("rst2_no_out", n_drain - d0, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
